// File: rtl/fir_pkg.sv
// Shared definitions for the FIR stream controller.
//   FIR_LATENCY : default number of fir_enable edges from sample accept to its y on fir_y
//   FIR_DATA_W  : default sample width (Q1.15 signed)
//   FIR_TAPS    : tap count of the attached FIR datapath
//   state_t     : controller FSM states
//   tok_t       : per-slot token carried alongside a sample through the FIR
package fir_pkg;

   localparam int unsigned FIR_LATENCY = 9;
   localparam int unsigned FIR_DATA_W  = 16;
   localparam int unsigned FIR_TAPS    = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH
   } state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } tok_t;

endpackage

// File: rtl/fir_out_fifo.sv
// First-word fall-through output buffer.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data this cycle (caller guarantees not full)
//   push_data : entry to write
//   pop       : consume the head entry (ignored when empty)
//   rd_data   : head entry, valid whenever empty is low
//   empty     : no entries held
//   count     : number of entries held, 0..DEPTH
module fir_out_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 17
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_ok;

   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // Depth is a power of two, so the pointers wrap on natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fir_stream_ctrl.sv
// Streaming controller wrapping a fixed-latency FIR datapath.
//   clk, rst     : clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last : input sample stream
//   fir_enable   : advance strobe to the FIR datapath
//   fir_x        : sample presented to the FIR (zero when not enabled)
//   fir_y        : FIR result, LATENCY enables behind its input
//   m_valid/m_ready/m_data/m_last : filtered output stream
//   busy         : controller not idle or output buffer non-empty
//   frame_count  : completed frames, wraps at 16 bits
// A token shift register tracks which FIR output slots carry real samples;
// after a frame's last sample the FIR is zero-stuffed until that sample exits.
module fir_stream_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned LATENCY    = FIR_LATENCY,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DATA_W     = FIR_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              fir_enable,
   output logic [DATA_W-1:0] fir_x,
   input  logic [DATA_W-1:0] fir_y,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy,
   output logic [15:0]       frame_count
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   state_t            state;
   state_t            state_next;
   tok_t              tok [LATENCY];
   logic [CW-1:0]     fifo_count;
   logic              fifo_empty;
   logic [DATA_W:0]   fifo_head;
   logic              space;
   logic              accept;
   logic              push;
   logic              push_last;

   // Space comes from the registered count only, so m_ready never reaches s_ready.
   assign space     = (32'(fifo_count) < FIFO_DEPTH);
   assign push_last = push & tok[LATENCY-1].last;

   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      accept     = 1'b0;
      fir_enable = 1'b0;
      fir_x      = '0;
      push       = 1'b0;
      if (!rst) begin
         case (state)
            ST_IDLE, ST_RUN: begin
               s_ready = space;
               accept  = s_valid & space;
               if (accept) begin
                  fir_enable = 1'b1;
                  fir_x      = s_data;
                  state_next = s_last ? ST_FLUSH : ST_RUN;
               end
            end
            ST_FLUSH: begin
               fir_enable = space;
            end
            default: state_next = ST_IDLE;
         endcase
         push = fir_enable & tok[LATENCY-1].valid;
         if (push_last) begin
            state_next = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            tok[i] <= '0;
         end
      end else if (fir_enable) begin
         tok[0] <= '{valid: accept, last: s_last & accept};
         for (int unsigned i = 1; i < LATENCY; i++) begin
            tok[i] <= tok[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count <= '0;
      end else if (push_last) begin
         frame_count <= frame_count + 16'd1;
      end
   end

   fir_out_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W + 1)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({fir_y, tok[LATENCY-1].last}),
      .pop       (m_valid & m_ready),
      .rd_data   (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Outputs are forced quiet during the reset cycle, before the FIFO clears.
   assign m_valid = ~rst & ~fifo_empty;
   assign m_data  = m_valid ? fifo_head[DATA_W:1] : '0;
   assign m_last  = m_valid & fifo_head[0];
   assign busy    = ~rst & ((state != ST_IDLE) | ~fifo_empty);

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Self-checking bench for fir_stream_ctrl with a behavioural 16-tap FIR
// (nfir_16tap, taps 64,128,...,8192,8192,...,128,64) closing the loop.
module tb_fir_stream_ctrl;

   localparam int unsigned LAT   = 9;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned W     = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [W-1:0]  s_data = '0;
   logic          s_last = 1'b0;
   logic          fir_enable;
   logic [W-1:0]  fir_x;
   logic [W-1:0]  fir_y;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [W-1:0]  m_data;
   logic          m_last;
   logic          busy;
   logic [15:0]   frame_count;

   fir_stream_ctrl #(
      .LATENCY    (LAT),
      .FIFO_DEPTH (DEPTH),
      .DATA_W     (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .fir_enable  (fir_enable),
      .fir_x       (fir_x),
      .fir_y       (fir_y),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .busy        (busy),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   function automatic longint tap(input int k);
      return (k < 8) ? (longint'(64) << k) : (longint'(64) << (15 - k));
   endfunction

   // ---------------- nfir_16tap: behavioural FIR datapath ----------------
   logic signed [W-1:0] fir_dl   [15];
   logic signed [W-1:0] fir_pipe [LAT];

   function automatic logic signed [W-1:0] fir_eval(input logic signed [W-1:0] x,
                                                    input logic signed [W-1:0] d [15]);
      longint acc;
      acc = tap(0) * longint'(x);
      for (int k = 1; k < 16; k++) acc += tap(k) * longint'(d[k-1]);
      return W'(acc >>> 15);
   endfunction

   assign fir_y = fir_pipe[LAT-1];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) fir_dl[i] <= '0;
         for (int i = 0; i < int'(LAT); i++) fir_pipe[i] <= '0;
      end else if (fir_enable) begin
         fir_dl[0] <= fir_x;
         for (int i = 1; i < 15; i++) fir_dl[i] <= fir_dl[i-1];
         fir_pipe[0] <= fir_eval(fir_x, fir_dl);
         for (int i = 1; i < int'(LAT); i++) fir_pipe[i] <= fir_pipe[i-1];
      end
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct { longint y; bit last; } exp_t;

   int     n_checks = 0;
   int     n_fail   = 0;
   longint hist [$];          // every value fed to the FIR since reset, incl. stuffed zeros
   exp_t   expq [$];
   longint out_log [$];
   bit     last_log [$];
   int     last_accepts = 0;
   int     stuff_cnt    = 0;
   int     enable_cnt   = 0;
   int     blocked_cnt  = 0;
   int     mr_mode      = 0;  // 0: m_ready high, 1: low, 2: random

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_accept(input logic [W-1:0] d, input bit last);
      longint acc;
      int     n;
      exp_t   e;
      hist.push_back(longint'($signed(d)));
      n   = hist.size();
      acc = 0;
      for (int k = 0; k < 16; k++)
         if (n - 1 - k >= 0) acc += tap(k) * hist[n-1-k];
      e.y    = acc >>> 15;
      e.last = last;
      expq.push_back(e);
      if (last) begin
         last_accepts++;
         // the frame's tail is flushed by LAT zero samples
         for (int i = 0; i < int'(LAT); i++) hist.push_back(0);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         check("rst_outputs", {s_ready, fir_enable, m_valid, m_last, busy, fir_x, m_data}, 0);
         hist.delete();
         expq.delete();
         last_accepts = 0;
      end else begin
         if (!fir_enable) check("fir_x_idle", fir_x, 0);
         if (fir_enable) enable_cnt++;
         if (s_valid && !s_ready) blocked_cnt++;
         if (s_valid && s_ready) begin
            check("accept_drive", {fir_enable, fir_x}, {1'b1, s_data});
            model_accept(s_data, s_last);
         end else if (fir_enable) begin
            stuff_cnt++;
         end
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL extra_output: got %0d expected no output at %0t",
                        $signed(m_data), $time);
            end else begin
               e = expq.pop_front();
               check("m_data", longint'($signed(m_data)), e.y);
               check("m_last", m_last, e.last);
            end
            out_log.push_back(longint'($signed(m_data)));
            last_log.push_back(m_last);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mr_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'b0;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [W-1:0] d, input logic l);
      bit acc;
      acc     = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got s_ready=0 expected accept of %0d", d);
      end
   endtask

   task automatic gap(input int n);
      s_valid = 1'b0;
      s_last  = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      bit done;
      done    = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      for (int t = 0; t < 1000; t++) begin
         @(negedge clk);
         if (!busy && !m_valid) begin
            done = 1'b1;
            break;
         end
      end
      check("drain_done", done, 1);
      check("drain_scoreboard_empty", expq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      s_last  = 1'b0;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic clear_logs();
      out_log.delete();
      last_log.delete();
      stuff_cnt   = 0;
      enable_cnt  = 0;
      blocked_cnt = 0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n_last;
      int fc0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_frame_count", frame_count, 0);
      check("post_reset_busy", busy, 0);
      @(posedge clk);
      #1;

      // single-beat frame
      clear_logs();
      send(16'd16384, 1'b1);
      wait_idle();
      check("single_count", out_log.size(), 1);
      if (out_log.size() == 1) begin
         check("single_data", out_log[0], 32);
         check("single_last", last_log[0], 1);
      end
      check("single_frame_count", frame_count, 1);
      check("single_stuffed", stuff_cnt, 9);
      check("single_busy", busy, 0);

      // 20-beat step
      do_reset();
      clear_logs();
      for (int i = 1; i <= 20; i++) send(16'd8192, 1'(i == 20));
      wait_idle();
      check("step_count", out_log.size(), 20);
      if (out_log.size() == 20) begin
         check("step_y0", out_log[0], 16);
         check("step_y1", out_log[1], 48);
         check("step_y2", out_log[2], 112);
         check("step_y3", out_log[3], 240);
         n_last = 0;
         foreach (last_log[i]) n_last += int'(last_log[i]);
         check("step_last_count", n_last, 1);
         check("step_last_pos", last_log[19], 1);
      end
      check("step_stuffed", stuff_cnt, 9);
      check("step_frame_count", frame_count, 1);

      // backpressure: m_ready low for the whole frame
      do_reset();
      clear_logs();
      mr_mode = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) send(W'($urandom_range(0, 65535)), 1'(i == 9));
      gap(30);
      @(negedge clk);
      check("bp_enables", enable_cnt, 13);
      check("bp_s_ready", s_ready, 0);
      check("bp_fir_enable", fir_enable, 0);
      check("bp_m_valid", m_valid, 1);
      mr_mode = 0;
      wait_idle();
      check("bp_count", out_log.size(), 10);

      // random stream with random backpressure
      do_reset();
      clear_logs();
      mr_mode = 2;
      for (int i = 0; i < 50; i++) begin
         if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
         send(W'($urandom_range(0, 65535)), 1'((i == 49) || ($urandom_range(0, 7) == 0)));
      end
      mr_mode = 0;
      wait_idle();
      check("rand_count", out_log.size(), 50);
      check("rand_frame_count", frame_count, last_accepts);

      // reset during FLUSH
      clear_logs();
      for (int i = 0; i < 5; i++) send(W'($urandom_range(0, 65535)), 1'(i == 4));
      gap(6);
      do_reset();
      @(negedge clk);
      check("rflush_m_valid", m_valid, 0);
      check("rflush_frame_count", frame_count, 0);
      check("rflush_busy", busy, 0);
      @(posedge clk);
      #1;
      clear_logs();
      send(16'd16384, 1'b1);
      wait_idle();
      check("rflush_next_count", out_log.size(), 1);
      if (out_log.size() == 1) check("rflush_next_data", out_log[0], 32);
      check("rflush_next_frame_count", frame_count, 1);

      // two frames back-to-back with s_valid held high
      clear_logs();
      fc0 = int'(frame_count);
      for (int i = 0; i < 4; i++) send(W'($urandom_range(0, 65535)), 1'(i == 3));
      for (int i = 0; i < 4; i++) send(W'($urandom_range(0, 65535)), 1'(i == 3));
      wait_idle();
      check("b2b_blocked_cycles", blocked_cnt, 9);
      check("b2b_frame_count", frame_count, fc0 + 2);
      check("b2b_count", out_log.size(), 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fir_stream_ctrl.md
FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 Parameter LATENCY, default 9; number of fir_enable edges from input sample accept to its y on fir_y.
REQ-002 Parameter FIFO_DEPTH, default 4; output buffer entries, power of two, minimum 2.
REQ-003 Parameter DATA_W, default 16; sample width, Q1.15 signed.
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 s_valid  input  1  upstream sample valid.
REQ-007 s_ready  output  1  controller accepts s_data this cycle.
REQ-008 s_data  input  DATA_W  input sample.
REQ-009 s_last  input  1  marks final sample of a frame.
REQ-010 fir_enable  output  1  advance strobe to the 16-tap FIR datapath.
REQ-011 fir_x  output  DATA_W  sample driven to the FIR.
REQ-012 fir_y  input  DATA_W  FIR output.
REQ-013 m_valid  output  1  output sample valid.
REQ-014 m_ready  input  1  downstream accepts m_data.
REQ-015 m_data  output  DATA_W  filtered sample.
REQ-016 m_last  output  1  final filtered sample of a frame.
REQ-017 busy  output  1  high whenever state is not IDLE or the FIFO is non-empty.
REQ-018 frame_count  output  16  completed frames, wraps at 65535 to 0.

Function
REQ-019 FSM states IDLE, RUN, FLUSH; space = (fifo_count < FIFO_DEPTH), registered count only, no m_ready->s_ready path.
REQ-020 s_ready = space in IDLE and RUN; 0 in FLUSH.
REQ-021 Accept = s_valid & s_ready; on accept, fir_enable=1, fir_x=s_data.
REQ-022 In FLUSH, fir_enable = space, fir_x = 0 (zero-stuffing, no token).
REQ-023 fir_enable=0 in all other cycles; fir_x=0 when fir_enable=0.
REQ-024 Token shift register tok[0..LATENCY-1] (valid+last bits) shifts only on fir_enable; tok[0] loads {accept, s_last&accept}.
REQ-025 On a fir_enable cycle with tok[LATENCY-1].valid=1, push {fir_y, tok[LATENCY-1].last} into the FIFO; at most one push per cycle.
REQ-026 Transitions: IDLE->RUN on accept without s_last; IDLE/RUN->FLUSH on accept with s_last; FLUSH->IDLE on the push whose last bit is 1.
REQ-027 frame_count increments on the push whose last bit is 1.
REQ-028 FIFO: first-word fall-through; m_valid = not empty; pop on m_valid & m_ready; simultaneous push and pop when full is not possible (push gated by space), when non-full both occur and count is unchanged.
REQ-029 Back-to-back frames: next frame accepted only after FLUSH->IDLE; no interleaving of frame samples.
REQ-030 Stalls (s_valid=0 in RUN or space=0) freeze tok and the FIR; no sample lost or duplicated.
REQ-031 Output order equals input order; exactly one output per accepted input.

Reset
REQ-032 On rst: state=IDLE, tok cleared, FIFO emptied, frame_count=0; s_ready=0, fir_enable=0, fir_x=0, m_valid=0, m_data=0, m_last=0, busy=0 in the cycle rst is high.
REQ-033 rst mid-RUN or mid-FLUSH discards all in-flight tokens and buffered outputs; first cycle after rst release behaves as IDLE with empty FIFO.

Structure
REQ-034 Shared package fir_pkg holds LATENCY default, DATA_W, tap count 16, and the state enumeration.
REQ-035 One sub-module fir_out_fifo (parameterised depth/width, FWFT, count output); FSM and token register live in fir_stream_ctrl.
REQ-036 Bench instantiates fir_stream_ctrl driving nfir_16tap with taps 64,128,...,8192,8192,...,128,64.

Verification
REQ-037 Single-beat frame 16384 with s_last, m_ready=1 -> one output m_data=32, m_last=1, frame_count=1, busy low after drain.
REQ-038 Step frame of 20 beats 8192, last on beat 20 -> outputs 16, 48, 112, 240, ... per REQ-031, m_last only on 20th, 9 zero-stuff enables in FLUSH.
REQ-039 m_ready=0 throughout a 10-beat frame -> fir_enable stops once fifo_count=4, s_ready=0; release m_ready -> all 10 outputs delivered in order.
REQ-040 Random s_valid/m_ready toggling over 50 random samples -> outputs bit-exact to golden model, no loss or duplication.
REQ-041 rst asserted during FLUSH -> m_valid=0 next cycle, frame_count=0, next frame's first output matches a clean-start run.
REQ-042 Two frames back-to-back with s_valid held high -> s_ready low during FLUSH, second frame starts after first m_last push, frame_count=2.
